// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder slice.
// Holds the FSM encoding, parameter defaults and the access-legality helper.
package dmem_responder_pkg;

    localparam int DEPTH_WORDS_DEFAULT = 256;
    localparam int LATENCY_DEFAULT     = 2;
    localparam int CNT_W               = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Misaligned, or word index beyond a power-of-two array of 2**idx_w words.
    function automatic logic access_error(input logic [31:0] addr, input int unsigned idx_w);
        logic [29:0] word;
        word = addr[31:2];
        return (addr[1:0] != 2'b00) || ((word >> idx_w) != 30'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with byte-lane write enables and a combinational read port.
// Contents are deliberately not reset so they survive a responder reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    input  logic [3:0]                     be,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
// Stores commit and loads sample at the acceptance edge; the response is replayed after LATENCY cycles.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int LATENCY     = LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_hold;
    logic             err_hold;

    logic             accept;
    logic             addr_err;
    logic             do_store;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      arr_rdata;
    logic [31:0]      load_data;

    assign accept    = req_valid && (state == IDLE);
    assign addr_err  = access_error(req_addr, IDX_W);
    assign word_idx  = req_addr[IDX_W+1:2];
    assign do_store  = accept && req_we && !addr_err;
    assign load_data = (req_we || addr_err) ? 32'd0 : arr_rdata;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (do_store),
        .idx   (word_idx),
        .wdata (req_wdata),
        .be    (req_be),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            rdata_hold <= 32'd0;
            err_hold   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready  <= 1'b0;
                        rdata_hold <= load_data;
                        err_hold   <= addr_err;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= load_data;
                            resp_err   <= addr_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata_hold;
                        resp_err   <= err_hold;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    // Outputs stay frozen until the initiator takes the response.
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
